// File: rtl/pio_pkg.sv
// Shared definitions for the PIO instruction path: frame format constants,
// memory geometry and the loader FSM state type.
package pio_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;
  localparam int MAX_LEN = 32;

  localparam logic       HDR_MARK = 1'b1;
  localparam logic [1:0] HDR_RSVD = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } loader_state_t;

  function automatic logic hdr_ok(input logic [7:0] b);
    return (b[7] == HDR_MARK) && (b[6:5] == HDR_RSVD);
  endfunction

  function automatic logic len_ok(input logic [7:0] b);
    return (b != 8'd0) && (b <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Host byte-stream loader: parses HDR/LEN/data frames and issues 16-bit writes
// into the instruction regfile, holding load_active while a frame is in flight.
module instruction_loader
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               abort,
  output logic [INSTR_W-1:0] write_data,
  output logic [ADDR_W-1:0]  write_addr,
  output logic               write_en,
  output logic               load_active,
  output logic               done,
  output logic               error
);

  loader_state_t      state_r;
  loader_state_t      state_nxt_s;
  logic [ADDR_W-1:0]  cur_addr_r;
  logic [5:0]         remaining_r;
  logic [7:0]         hi_r;
  logic [INSTR_W-1:0] write_data_r;
  logic [ADDR_W-1:0]  write_addr_r;
  logic               load_active_r;
  logic               error_r;
  logic               abort_s;
  logic               ready_s;
  logic               xfer_s;

  // abort only matters once a frame has started; it also blocks the handshake
  assign abort_s = abort && (state_r != ST_IDLE);
  assign xfer_s  = s_valid && ready_s;

  // Byte acceptance per state
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_LEN, ST_DATA_HI, ST_DATA_LO: ready_s = !abort_s;
      default:                                 ready_s = 1'b0;
    endcase
  end

  // Next-state decode; abort outranks everything outside IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (xfer_s && hdr_ok(s_data)) state_nxt_s = ST_LEN;
          else                          state_nxt_s = ST_IDLE;
        end
        ST_LEN: begin
          if (xfer_s) state_nxt_s = len_ok(s_data) ? ST_DATA_HI : ST_IDLE;
          else        state_nxt_s = ST_LEN;
        end
        ST_DATA_HI: begin
          if (xfer_s) state_nxt_s = ST_DATA_LO;
          else        state_nxt_s = ST_DATA_HI;
        end
        ST_DATA_LO: begin
          if (xfer_s) state_nxt_s = ST_WRITE;
          else        state_nxt_s = ST_DATA_LO;
        end
        ST_WRITE: state_nxt_s = (remaining_r == 6'd1) ? ST_DONE : ST_DATA_HI;
        ST_DONE:  state_nxt_s = ST_IDLE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, counters, byte capture and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cur_addr_r    <= '0;
      remaining_r   <= 6'd0;
      hi_r          <= 8'd0;
      write_data_r  <= '0;
      write_addr_r  <= '0;
      load_active_r <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      load_active_r <= (state_nxt_s != ST_IDLE);
      error_r       <= xfer_s && (((state_r == ST_IDLE) && !hdr_ok(s_data)) ||
                                  ((state_r == ST_LEN)  && !len_ok(s_data)));
      case (state_r)
        ST_IDLE: begin
          if (xfer_s && hdr_ok(s_data)) cur_addr_r <= s_data[ADDR_W-1:0];
        end
        ST_LEN: begin
          if (xfer_s) remaining_r <= s_data[5:0];
        end
        ST_DATA_HI: begin
          if (xfer_s) hi_r <= s_data;
        end
        ST_DATA_LO: begin
          if (xfer_s) begin
            write_data_r <= {hi_r, s_data};
            write_addr_r <= cur_addr_r;
          end
        end
        ST_WRITE: begin
          if (!abort_s) begin
            cur_addr_r  <= cur_addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready     = ready_s;
  assign write_data  = write_data_r;
  assign write_addr  = write_addr_r;
  assign write_en    = (state_r == ST_WRITE) && !abort_s;
  assign done        = (state_r == ST_DONE) && !abort_s;
  assign load_active = load_active_r;
  assign error       = error_r;

endmodule
